// File: rtl/cipher_block_loader.sv
// cipher_block_loader: packs a byte stream into AES-128 key/data 4x4 state arrays and presents them with valid/ready.
// Optional feature macro CIPHER_LOADER_KEY_REUSE_EN adds key_reload to keep the key and stream data-only blocks.
module cipher_block_loader #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0][3:0][7:0] out_key,
    output logic [3:0][3:0][7:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef CIPHER_LOADER_KEY_REUSE_EN
    ,
    input  logic                 key_reload
`endif
);
    localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD_KEY,
        LOAD_DATA,
        PRESENT
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0][3:0][7:0] key_q, key_d;
    logic [3:0][3:0][7:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 accept;
    logic                 last_byte;

    // Nothing is taken while presenting, so a block is never loaded and consumed on the same edge.
    assign in_ready  = !rst && (state_q != PRESENT);
    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            LOAD_KEY: begin
                if (accept) begin
                    key_d[cnt_q[3:2]][cnt_q[1:0]] = in_byte;
                    cnt_d = last_byte ? 4'd0 : cnt_q + 4'd1;
                    if (last_byte) begin
                        state_d = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (accept) begin
                    data_d[cnt_q[3:2]][cnt_q[1:0]] = in_byte;
                    cnt_d = last_byte ? 4'd0 : cnt_q + 4'd1;
                    if (last_byte) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = LOAD_KEY;
`ifdef CIPHER_LOADER_KEY_REUSE_EN
                    if (!key_reload) begin
                        state_d = LOAD_DATA;
                    end
`endif
                end
            end
            default: begin
                state_d = LOAD_KEY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_KEY;
            cnt_q   <= 4'd0;
            key_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_key   = key_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cipher_block_loader.sv
// Randomised scoreboard bench for cipher_block_loader: driver pushes expected blocks, a negedge monitor pops and compares.
module tb_cipher_block_loader;
    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           in_byte;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][3:0][7:0] out_key;
    logic [3:0][3:0][7:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
`ifdef CIPHER_LOADER_KEY_REUSE_EN
    logic                 key_reload = 1'b1;
`endif

    always #5 clk = ~clk;

    cipher_block_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_key   (out_key),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CIPHER_LOADER_KEY_REUSE_EN
        ,
        .key_reload(key_reload)
`endif
    );

    typedef struct packed {
        logic [15:0][7:0] key;
        logic [15:0][7:0] data;
    } blk_t;

    int               checks = 0;
    int               failures = 0;
    blk_t             exp_q[$];
    logic [15:0][7:0] model_key = '0;
    int               ready_mode = 0;
    bit               mon_en = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
        endcase
    end

    blk_t                 cur;
    logic [3:0][3:0][7:0] snap_key, snap_data;
    bit                   prev_valid = 0;
    bit                   expect_low = 0;
    int                   blk_n = 0;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_valid = 0;
            expect_low = 0;
        end else if (expect_low) begin
            chk(!out_valid, "valid_drop", 64'(out_valid), 64'd0);
            expect_low = 0;
            prev_valid = 0;
        end else begin
            if (out_valid) begin
                chk(!in_ready, "in_ready_present", 64'(in_ready), 64'd0);
                if (prev_valid)
                    chk(out_key == snap_key && out_data == snap_data, "present_stable",
                        64'(out_data[1:0]), 64'(snap_data[1:0]));
                snap_key  = out_key;
                snap_data = out_data;
                if (out_ready) begin
                    chk(exp_q.size() != 0, "unexpected_block", 64'(exp_q.size()), 64'd1);
                    if (exp_q.size() != 0) begin
                        bit okk = 1, okd = 1;
                        logic [7:0] ak = 0, ek = 0, ad = 0, ed = 0;
                        cur = exp_q.pop_front();
                        for (int n = 0; n < 16; n++) begin
                            if (okk && out_key[2'(n / 4)][2'(n % 4)] !== cur.key[4'(n)]) begin
                                okk = 0; ak = out_key[2'(n / 4)][2'(n % 4)]; ek = cur.key[4'(n)];
                            end
                            if (okd && out_data[2'(n / 4)][2'(n % 4)] !== cur.data[4'(n)]) begin
                                okd = 0; ad = out_data[2'(n / 4)][2'(n % 4)]; ed = cur.data[4'(n)];
                            end
                        end
                        chk(okk, "block_key", 64'(ak), 64'(ek));
                        chk(okd, "block_data", 64'(ad), 64'(ed));
                        $display("block %0d consumed key[0][0]=%h data[0][0]=%h", blk_n, out_key[0][0], out_data[0][0]);
                        blk_n++;
                    end
                    expect_low = 1;
                end
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc = 0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk(acc, "byte_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_block(input logic [15:0][7:0] k, input logic [15:0][7:0] d,
                              input bit with_key, input int gap_pct);
        blk_t e;
        if (with_key)
            for (int n = 0; n < 16; n++) send_byte(k[4'(n)], gap_pct);
        for (int n = 0; n < 16; n++) send_byte(d[4'(n)], gap_pct);
        e.key  = with_key ? k : model_key;
        e.data = d;
        if (with_key) model_key = k;
        exp_q.push_back(e);
        chk(out_valid, "valid_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic rand_block(input int gap_pct);
        logic [15:0][7:0] k, d;
        for (int n = 0; n < 16; n++) begin
            k[4'(n)] = 8'($urandom);
            d[4'(n)] = 8'($urandom);
        end
        send_block(k, d, 1, gap_pct);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][7:0] k, d;
        logic [127:0] kv, dv;

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        @(negedge clk);
        chk(!in_ready, "in_ready_rst", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk(!out_valid, "rst_valid", 64'(out_valid), 64'd0);
        chk(out_key == '0 && out_data == '0, "rst_outputs", 64'(out_key[1:0]), 64'd0);
        rst = 1'b0; mon_en = 1;
        @(negedge clk);
        chk(in_ready, "in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Counting stream 00..1F, back to back
        for (int n = 0; n < 16; n++) begin
            k[4'(n)] = 8'(n);
            d[4'(n)] = 8'(n + 16);
        end
        send_block(k, d, 1, 0);
        chk(out_key[1][2] == 8'h06, "count_key_1_2", 64'(out_key[1][2]), 64'h06);
        chk(out_data[3][3] == 8'h1F, "count_data_3_3", 64'(out_data[3][3]), 64'h1F);
        wait_drain();

        // FIPS-197 Appendix B vector
        kv = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        dv = 128'h3243f6a8885a308d313198a2e0370734;
        for (int n = 0; n < 16; n++) begin
            k[4'(n)] = 8'(kv >> (8 * (15 - n)));
            d[4'(n)] = 8'(dv >> (8 * (15 - n)));
        end
        send_block(k, d, 1, 0);
        chk(out_key[0][0] == 8'h2b, "fips_key_0_0", 64'(out_key[0][0]), 64'h2b);
        chk(out_data[0][0] == 8'h32, "fips_data_0_0", 64'(out_data[0][0]), 64'h32);
        wait_drain();

        // Downstream stall with the next byte already offered
        ready_mode = 2;
        rand_block(0);
        in_valid = 1'b1; in_byte = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk(!in_ready, "stall_in_ready", 64'(in_ready), 64'd0);
            chk(out_valid, "stall_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        for (int n = 0; n < 16; n++) begin
            k[4'(n)] = 8'($urandom);
            d[4'(n)] = 8'($urandom);
        end
        k[0] = 8'h5A;
        send_block(k, d, 1, 0);
        wait_drain();

        // Random input gaps and random downstream ready
        ready_mode = 1;
        repeat (3) rand_block(50);
        wait_drain();
        ready_mode = 0;

        // Reset in the middle of a key/data block
        for (int n = 0; n < 20; n++) send_byte(8'($urandom) | 8'h01, 0);
        rst = 1'b1;
        @(negedge clk);
        chk(!in_ready, "in_ready_mid_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk(!out_valid, "mid_rst_valid", 64'(out_valid), 64'd0);
        chk(out_key == '0 && out_data == '0, "mid_rst_outputs", 64'(out_key[1:0]), 64'd0);
        rst = 1'b0;
        rand_block(0);
        wait_drain();

`ifdef CIPHER_LOADER_KEY_REUSE_EN
        // Keep the key: the next block carries data bytes only
        key_reload = 1'b0;
        rand_block(0);
        wait_drain();
        key_reload = 1'b1;
        for (int n = 0; n < 16; n++) d[4'(n)] = 8'(8'hA0 + n);
        send_block(k, d, 0, 0);
        chk(out_data[0][0] == 8'hA0, "reuse_data_0_0", 64'(out_data[0][0]), 64'hA0);
        wait_drain();
        rand_block(25);
        wait_drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
